// File: rtl/switch_bounce_emulator.sv
// switch_bounce_emulator
//
// Stands in for a physical key in closed-loop self-test of the key-filter
// chain. On an accepted command it either does nothing (level unchanged),
// makes one clean edge, or emits a pseudo-random chattering burst. The burst
// lasts a fixed window, is forced to the requested level when the window
// expires, and then holds quiet for a settle period.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   cmd_valid      command request
//   cmd_ready      command can be accepted (state is IDLE)
//   cmd_level      requested final level
//   cmd_bounce_en  1 = chattering burst, 0 = single clean edge
//   switch_out     emulated switch level (registered)
//   busy           burst or settle in progress (= !cmd_ready)
//   toggle_count   edges emitted by the current/most recent command, saturating
module switch_bounce_emulator #(
    parameter int          CLOCK_HZ             = 12_000_000,
    parameter int          BOUNCE_WINDOW_CYCLES = CLOCK_HZ / 500,
    parameter int          MIN_STEP_CYCLES      = CLOCK_HZ / 1_000_000,
    parameter int          STEP_MASK            = 1023,
    parameter int          SETTLE_CYCLES        = CLOCK_HZ / 100_000,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1,
    parameter logic        INIT_LEVEL           = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_level,
    input  logic        cmd_bounce_en,
    output logic        switch_out,
    output logic        busy,
    output logic [15:0] toggle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam int WIN_MAX  = BOUNCE_WINDOW_CYCLES - 1;
    localparam int WIN_W    = (WIN_MAX < 1) ? 1 : $clog2(WIN_MAX + 1);
    // Sized for the largest reload value so MIN + masked LFSR never wraps.
    localparam int STEP_MAX = MIN_STEP_CYCLES + STEP_MASK;
    localparam int STEP_W   = (STEP_MAX < 2) ? 1 : $clog2(STEP_MAX + 1);
    localparam int SET_W    = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [WIN_W-1:0]  WIN_INIT   = WIN_W'(WIN_MAX);
    localparam logic [STEP_W-1:0] STEP_MIN   = STEP_W'(MIN_STEP_CYCLES);
    localparam logic [15:0]       MASK16     = 16'(STEP_MASK);
    localparam logic [SET_W-1:0]  SET_INIT   = SET_W'(SETTLE_CYCLES);
    localparam bit                NO_SETTLE  = (SETTLE_CYCLES == 0);
    localparam logic [15:0]       LFSR_POLY  = 16'hB400;

    state_t             state_q, state_d;
    logic               sw_q, sw_d;
    logic               target_q, target_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [SET_W-1:0]   settle_q, settle_d;

    logic [15:0]        lfsr_next;
    logic [STEP_W-1:0]  step_reload;
    logic [15:0]        count_inc;

    // Galois right-shift; a nonzero seed never reaches the all-zero state.
    assign lfsr_next   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    assign step_reload = STEP_MIN + STEP_W'(lfsr_q & MASK16);
    assign count_inc   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        target_d = target_q;
        count_d  = count_q;
        lfsr_d   = lfsr_q;
        window_d = window_q;
        step_d   = step_q;
        settle_d = settle_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    count_d = 16'd0;
                    if (cmd_level != sw_q) begin
                        count_d = 16'd1;
                        if (!cmd_bounce_en) begin
                            sw_d = cmd_level;
                        end else begin
                            sw_d     = ~sw_q;
                            target_d = cmd_level;
                            window_d = WIN_INIT;
                            step_d   = step_reload;
                            lfsr_d   = lfsr_next;
                            state_d  = BOUNCE;
                        end
                    end
                end
            end

            BOUNCE: begin
                if (window_q == '0) begin
                    // Window expiry takes priority over a due step toggle.
                    if (sw_q != target_q) begin
                        sw_d    = target_q;
                        count_d = count_inc;
                    end
                    settle_d = SET_INIT;
                    state_d  = NO_SETTLE ? IDLE : SETTLE;
                end else begin
                    window_d = window_q - 1'b1;
                    if (step_q == STEP_W'(1)) begin
                        sw_d    = ~sw_q;
                        count_d = count_inc;
                        step_d  = step_reload;
                        lfsr_d  = lfsr_next;
                    end else begin
                        step_d = step_q - 1'b1;
                    end
                end
            end

            SETTLE: begin
                settle_d = settle_q - 1'b1;
                if (settle_q <= SET_W'(1)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            sw_q     <= INIT_LEVEL;
            target_q <= INIT_LEVEL;
            count_q  <= 16'd0;
            lfsr_q   <= LFSR_SEED;
            window_q <= '0;
            step_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            target_q <= target_d;
            count_q  <= count_d;
            lfsr_q   <= lfsr_d;
            window_q <= window_d;
            step_q   <= step_d;
            settle_q <= settle_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = ~cmd_ready;
    assign switch_out   = sw_q;
    assign toggle_count = count_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
module tb_switch_bounce_emulator;

    localparam int          BW   = 200;
    localparam int          MS   = 4;
    localparam int          MK   = 15;
    localparam int          SC   = 20;
    localparam int          TOT  = BW + SC;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_level = 1'b0;
    logic        cmd_bounce_en = 1'b0;
    logic        cmd_ready;
    logic        busy;
    logic        switch_out;
    logic [15:0] toggle_count;

    switch_bounce_emulator #(
        .BOUNCE_WINDOW_CYCLES(BW),
        .MIN_STEP_CYCLES     (MS),
        .STEP_MASK           (MK),
        .SETTLE_CYCLES       (SC),
        .LFSR_SEED           (SEED),
        .INIT_LEVEL          (1'b0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_level    (cmd_level),
        .cmd_bounce_en(cmd_bounce_en),
        .switch_out   (switch_out),
        .busy         (busy),
        .toggle_count (toggle_count)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_lvl;
    logic [15:0] m_lfsr;
    logic        wave     [0:TOT];
    logic        wave_ref [0:TOT];

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cmd_valid = 1'b0;
        tick();
        reset = 1'b0;
        m_lvl = 1'b0;
        m_lfsr = SEED;
    endtask

    // Expected waveform from the timing rules: each toggle schedules the next
    // at an absolute edge number; toggles only land strictly inside the window;
    // the window end forces the target level.
    task automatic run_bounce(input logic tgt, input string tag);
        logic        e_lvl [0:TOT];
        int          e_cnt [0:TOT];
        logic [15:0] l;
        logic        lv, prev;
        int          t, c, low_cnt, last_edge, min_gap, edges;

        l = m_lfsr;
        lv = ~m_lvl;
        c = 1;
        t = MS + int'(l & 16'(MK));
        l = lfsr_adv(l);
        e_lvl[0] = lv;
        e_cnt[0] = 1;
        for (int k = 1; k <= TOT; k++) begin
            if (k < BW && k == t) begin
                lv = ~lv;
                c++;
                t = k + MS + int'(l & 16'(MK));
                l = lfsr_adv(l);
            end
            if (k == BW && lv != tgt) begin
                lv = tgt;
                c++;
            end
            e_lvl[k] = lv;
            e_cnt[k] = c;
        end

        cmd_valid = 1'b1;
        cmd_level = tgt;
        cmd_bounce_en = 1'b1;
        prev = m_lvl;
        low_cnt = 0;
        last_edge = -1;
        min_gap = 1 << 30;
        edges = 0;
        for (int k = 0; k <= TOT; k++) begin
            tick();
            cmd_valid = 1'b0;
            cmd_bounce_en = 1'b0;
            wave[k] = switch_out;
            n_checks += 3;
            if (switch_out !== e_lvl[k]) begin
                n_fail++;
                $display("FAIL %s switch_out edge %0d: got %b want %b", tag, k, switch_out, e_lvl[k]);
            end
            if (toggle_count !== 16'(e_cnt[k])) begin
                n_fail++;
                $display("FAIL %s toggle_count edge %0d: got %0d want %0d", tag, k, toggle_count, e_cnt[k]);
            end
            if (cmd_ready !== (k >= TOT)) begin
                n_fail++;
                $display("FAIL %s cmd_ready edge %0d: got %b want %b", tag, k, cmd_ready, (k >= TOT));
            end
            if (cmd_ready === 1'b0) low_cnt++;
            if (switch_out !== prev) begin
                edges++;
                if (k < BW) begin
                    if (last_edge >= 0 && (k - last_edge) < min_gap) min_gap = k - last_edge;
                    last_edge = k;
                end
            end
            prev = switch_out;
        end

        n_checks += 5;
        if (low_cnt != TOT) begin
            n_fail++;
            $display("FAIL %s ready_low_cycles: got %0d want %0d", tag, low_cnt, TOT);
        end
        if (toggle_count[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s count_odd: got %0d want odd", tag, toggle_count);
        end
        if (toggle_count !== 16'(edges)) begin
            n_fail++;
            $display("FAIL %s count_vs_edges: got %0d want %0d", tag, toggle_count, edges);
        end
        if (min_gap < MS) begin
            n_fail++;
            $display("FAIL %s min_spacing: got %0d want >=%0d", tag, min_gap, MS);
        end
        if (switch_out !== tgt) begin
            n_fail++;
            $display("FAIL %s final_level: got %b want %b", tag, switch_out, tgt);
        end
        m_lvl = tgt;
        m_lfsr = l;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_lvl = 1'b0;
        m_lfsr = SEED;
        for (int i = 0; i < 10; i++) tick();
        n_checks += 4;
        if (switch_out !== 1'b0) begin n_fail++; $display("FAIL reset switch_out: got %b want 0", switch_out); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        if (toggle_count !== 16'd0) begin n_fail++; $display("FAIL reset toggle_count: got %0d want 0", toggle_count); end
    endtask

    task automatic test_clean;
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        cmd_bounce_en = 1'b0;
        tick();
        cmd_valid = 1'b0;
        m_lvl = 1'b1;
        n_checks += 3;
        if (switch_out !== 1'b1) begin n_fail++; $display("FAIL clean switch_out: got %b want 1", switch_out); end
        if (toggle_count !== 16'd1) begin n_fail++; $display("FAIL clean toggle_count: got %0d want 1", toggle_count); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL clean cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_same_level;
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        cmd_bounce_en = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_bounce_en = 1'b0;
        n_checks += 3;
        if (switch_out !== 1'b1) begin n_fail++; $display("FAIL same switch_out: got %b want 1", switch_out); end
        if (toggle_count !== 16'd0) begin n_fail++; $display("FAIL same toggle_count: got %0d want 0", toggle_count); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL same cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_back_to_back;
        logic lvl;
        for (int i = 0; i < 24; i++) begin
            lvl = 1'($urandom_range(0, 1));
            cmd_valid = 1'b1;
            cmd_level = lvl;
            cmd_bounce_en = 1'b0;
            tick();
            n_checks += 3;
            if (switch_out !== lvl) begin n_fail++; $display("FAIL b2b switch_out %0d: got %b want %b", i, switch_out, lvl); end
            if (toggle_count !== ((lvl != m_lvl) ? 16'd1 : 16'd0)) begin
                n_fail++;
                $display("FAIL b2b toggle_count %0d: got %0d want %0d", i, toggle_count, (lvl != m_lvl));
            end
            if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b cmd_ready %0d: got %b want 1", i, cmd_ready); end
            m_lvl = lvl;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_bounce;
        do_reset();
        tick();
        run_bounce(1'b1, "bounce01");
        wave_ref = wave;
    endtask

    task automatic test_repeatable;
        int diffs;
        do_reset();
        tick();
        run_bounce(1'b1, "repeat01");
        diffs = 0;
        for (int k = 0; k <= TOT; k++) if (wave[k] !== wave_ref[k]) diffs++;
        n_checks++;
        if (diffs != 0) begin n_fail++; $display("FAIL repeat waveform: got %0d differing cycles want 0", diffs); end
        // LFSR state carries across commands.
        run_bounce(1'b0, "chain10");
        for (int i = 0; i < 1 + $urandom_range(0, 3); i++) tick();
        run_bounce(1'b1, "chain01");
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        tick();
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        cmd_bounce_en = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_bounce_en = 1'b0;
        for (int i = 0; i < 49; i++) tick();
        reset = 1'b1;
        tick();
        n_checks += 4;
        if (switch_out !== 1'b0) begin n_fail++; $display("FAIL abort switch_out: got %b want 0", switch_out); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort cmd_ready: got %b want 1", cmd_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", busy); end
        if (toggle_count !== 16'd0) begin n_fail++; $display("FAIL abort toggle_count: got %0d want 0", toggle_count); end
        reset = 1'b0;
        m_lvl = 1'b0;
        m_lfsr = SEED;
        test_clean();
        run_bounce(1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_same_level();
        test_back_to_back();
        test_bounce();
        test_repeatable();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
